tile_blitter: RTL and testbench

- Parametrised successor to the fixed 4x4 shaded-tile drawer. Renders one square tile of TILE_SIZE x TILE_SIZE pixels per request, pixel by pixel, into the vga_adapter write port (x, y, colour, plot).
- Sits between the dungeon generator / game FSM (request side) and vga_adapter (pixel side).
- Adds over the old drawer:
  - start/ready/done handshake;
  - selectable tile type (palette);
  - render mode: shaded, solid or outline;
  - screen-edge clipping;
  - a hold input that stalls rendering.

---
 rtl/tile_pkg.sv | 68 ++++++
 rtl/tile_shader.sv | 30 +++
 rtl/tile_blitter.sv | 124 ++++++++++++
 tb/tb_tile_blitter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared mode encodings, palette and shade selection for the tile blitter
package tile_pkg;

   typedef enum logic [1:0] {
      MODE_SHADED  = 2'd0,
      MODE_SOLID   = 2'd1,
      MODE_OUTLINE = 2'd2,
      MODE_RSVD    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      SHADE_LIGHT = 2'd0,
      SHADE_MID   = 2'd1,
      SHADE_DARK  = 2'd2,
      SHADE_NONE  = 2'd3
   } shade_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [8:0] FLOOR_LIGHT  = 9'b101_010_010;
   localparam logic [8:0] FLOOR_MID    = 9'b101_010_000;
   localparam logic [8:0] FLOOR_DARK   = 9'b010_000_000;
   localparam logic [8:0] WALL_LIGHT   = 9'b110_110_110;
   localparam logic [8:0] WALL_MID     = 9'b100_100_100;
   localparam logic [8:0] WALL_DARK    = 9'b010_010_010;
   localparam logic [8:0] MARK_LIGHT   = 9'b111_111_000;
   localparam logic [8:0] MARK_MID     = 9'b110_110_000;
   localparam logic [8:0] MARK_DARK    = 9'b011_011_000;

   // ts is the tile edge length; r/c are zero-extended row/column
   function automatic shade_e shade_sel(input logic [4:0] r, input logic [4:0] c,
                                        input logic [4:0] ts, input logic [1:0] mode);
      logic [4:0] last;
      logic       border;
      shade_e     s;
      last   = ts - 5'd1;
      border = (r == 5'd0) || (c == 5'd0) || (r == last) || (c == last);
      case (mode)
         MODE_SHADED: begin
            if (r == 5'd0)      s = SHADE_LIGHT;
            else if (r == last) s = SHADE_DARK;
            else if (c == 5'd0) s = SHADE_DARK;
            else if (c == last) s = SHADE_LIGHT;
            else                s = SHADE_MID;
         end
         MODE_OUTLINE: s = border ? SHADE_DARK : SHADE_NONE;
         default:      s = SHADE_MID;
      endcase
      return s;
   endfunction

   function automatic logic [8:0] palette(input logic [1:0] t, input shade_e s);
      logic [8:0] col;
      col = 9'd0;
      case (t)
         2'd0: col = (s == SHADE_LIGHT) ? FLOOR_LIGHT : (s == SHADE_DARK) ? FLOOR_DARK : FLOOR_MID;
         2'd1: col = (s == SHADE_LIGHT) ? WALL_LIGHT  : (s == SHADE_DARK) ? WALL_DARK  : WALL_MID;
         2'd3: col = (s == SHADE_LIGHT) ? MARK_LIGHT  : (s == SHADE_DARK) ? MARK_DARK  : MARK_MID;
         default: col = 9'd0;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/tile_shader.sv
// rtl/tile_shader.sv - combinational map from (row, column, type, mode) to pixel colour and enable
module tile_shader
   import tile_pkg::*;
#(
   parameter int TILE_SIZE = 4,
   parameter int TYPE_W    = 2,
   parameter int COLOUR_W  = 9
) (
   input  logic [$clog2(TILE_SIZE)-1:0] r,
   input  logic [$clog2(TILE_SIZE)-1:0] c,
   input  logic [TYPE_W-1:0]            tile_type,
   input  logic [1:0]                   mode,
   output logic [COLOUR_W-1:0]          colour,
   output logic                         pixel_en
);

   shade_e sel;
   logic   type_known;

   always_comb begin
      sel        = shade_sel(5'(r), 5'(c), 5'(TILE_SIZE), mode);
      type_known = (32'(tile_type) < 32'd4);
      pixel_en   = (sel != SHADE_NONE);
      colour     = '0;
      // Types beyond the four palette entries draw black
      if (type_known)
         colour = COLOUR_W'(palette(2'(tile_type), sel));
   end

endmodule

// File: rtl/tile_blitter.sv
// rtl/tile_blitter.sv - renders one TILE_SIZE square tile per request into the vga_adapter write port
module tile_blitter
   import tile_pkg::*;
#(
   parameter int TILE_SIZE = 4,
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int COLOUR_W  = 9,
   parameter int SCREEN_W  = 160,
   parameter int SCREEN_H  = 120,
   parameter int TYPE_W    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                ready,
   input  logic [X_W-1:0]      px,
   input  logic [Y_W-1:0]      py,
   input  logic [TYPE_W-1:0]   tile_type,
   input  logic [1:0]          mode,
   input  logic                hold,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   localparam int LW = $clog2(TILE_SIZE);
   localparam int CW = 2 * LW;
   localparam logic [CW-1:0] LAST_IDX = CW'(TILE_SIZE * TILE_SIZE - 1);

   state_e              state, state_next;
   logic [CW-1:0]       idx;
   logic [X_W-1:0]      org_x;
   logic [Y_W-1:0]      org_y;
   logic [TYPE_W-1:0]   t_type;
   logic [1:0]          t_mode;

   logic [LW-1:0]       col_c, row_r;
   logic [X_W:0]        sum_x;
   logic [Y_W:0]        sum_y;
   logic                clipped;
   logic [COLOUR_W-1:0] shade_colour;
   logic                pixel_en;

   assign col_c   = idx[LW-1:0];
   assign row_r   = idx[CW-1:LW];
   assign sum_x   = {1'b0, org_x} + (X_W+1)'(col_c);
   assign sum_y   = {1'b0, org_y} + (Y_W+1)'(row_r);
   assign clipped = (sum_x >= (X_W+1)'(SCREEN_W)) || (sum_y >= (Y_W+1)'(SCREEN_H));

   tile_shader #(
      .TILE_SIZE (TILE_SIZE),
      .TYPE_W    (TYPE_W),
      .COLOUR_W  (COLOUR_W)
   ) u_shader (
      .r         (row_r),
      .c         (col_c),
      .tile_type (t_type),
      .mode      (t_mode),
      .colour    (shade_colour),
      .pixel_en  (pixel_en)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      ready      = (state == ST_IDLE);
      busy       = (state == ST_DRAW);
      case (state)
         ST_IDLE: if (start) state_next = ST_DRAW;
         ST_DRAW: if (!hold && idx == LAST_IDX) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Pixel outputs are registered one cycle behind the counter value they describe
   always_ff @(posedge clk) begin
      if (reset) begin
         idx    <= '0;
         org_x  <= '0;
         org_y  <= '0;
         t_type <= '0;
         t_mode <= '0;
         vga_x  <= '0;
         vga_y  <= '0;
         colour <= '0;
         plot   <= 1'b0;
         done   <= 1'b0;
      end else begin
         plot <= 1'b0;
         done <= (state == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  org_x  <= px;
                  org_y  <= py;
                  t_type <= tile_type;
                  t_mode <= mode;
                  idx    <= '0;
               end
            end
            ST_DRAW: begin
               if (!hold) begin
                  vga_x  <= sum_x[X_W-1:0];
                  vga_y  <= sum_y[Y_W-1:0];
                  colour <= shade_colour;
                  plot   <= pixel_en && !clipped;
                  idx    <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tile_blitter.sv
// tb/tb_tile_blitter.sv - directed self-checking bench for tile_blitter
module tb_tile_blitter;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       start4, start8;
   logic [7:0] px;
   logic [6:0] py;
   logic [1:0] tile_type;
   logic [1:0] mode;
   logic       hold;

   logic       ready4, plot4, busy4, done4;
   logic [7:0] vga_x4;
   logic [6:0] vga_y4;
   logic [8:0] colour4;

   logic       ready8, plot8, busy8, done8;
   logic [7:0] vga_x8;
   logic [6:0] vga_y8;
   logic [8:0] colour8;

   int n_checks = 0;
   int n_errors = 0;

   int q_x[$], q_y[$], q_c[$], q_cyc[$];
   int n_done, done_cyc, ready_at_done;

   always #10 CLOCK_50 = ~CLOCK_50;

   tile_blitter #(.TILE_SIZE(4)) dut4 (
      .clk(CLOCK_50), .reset(reset), .start(start4), .ready(ready4),
      .px(px), .py(py), .tile_type(tile_type), .mode(mode), .hold(hold),
      .vga_x(vga_x4), .vga_y(vga_y4), .colour(colour4), .plot(plot4),
      .busy(busy4), .done(done4)
   );

   tile_blitter #(.TILE_SIZE(8)) dut8 (
      .clk(CLOCK_50), .reset(reset), .start(start8), .ready(ready8),
      .px(px), .py(py), .tile_type(tile_type), .mode(mode), .hold(hold),
      .vga_x(vga_x8), .vga_y(vga_y8), .colour(colour8), .plot(plot8),
      .busy(busy8), .done(done8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Accept a tile on dut4 and log every plot for a fixed window of cycles
   task automatic run_tile4(input int x0, input int y0, input int t, input int m,
                            input int hold_at, input int hold_len,
                            input bit busy_start, input bit done_start, input int window);
      int cyc;
      q_x.delete(); q_y.delete(); q_c.delete(); q_cyc.delete();
      n_done = 0; done_cyc = -1; ready_at_done = -1;
      px = 8'(x0); py = 7'(y0); tile_type = 2'(t); mode = 2'(m);
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      cyc = 0;
      while (cyc < window) begin
         tick();
         cyc++;
         if (plot4) begin
            q_x.push_back(int'(vga_x4)); q_y.push_back(int'(vga_y4));
            q_c.push_back(int'(colour4)); q_cyc.push_back(cyc);
         end
         if (done4) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               ready_at_done = int'(ready4);
            end
         end
         if (hold_len > 0 && cyc == hold_at)            hold = 1'b1;
         if (hold_len > 0 && cyc == hold_at + hold_len) hold = 1'b0;
         if (busy_start && cyc == 5) start4 = 1'b1;
         if (busy_start && cyc == 6) start4 = 1'b0;
         if (done_start && cyc == 16) start4 = 1'b1;
         if (done_start && cyc == 17) start4 = 1'b0;
      end
      start4 = 1'b0;
      hold = 1'b0;
   endtask

   initial begin
      int bad, cnt, cyc;
      reset = 1'b1; start4 = 1'b0; start8 = 1'b0; hold = 1'b0;
      px = '0; py = '0; tile_type = '0; mode = '0;
      tick(); tick();
      check("rst_ready", ready4, 1);
      check("rst_busy", busy4, 0);
      check("rst_done", done4, 0);
      check("rst_plot", plot4, 0);
      check("rst_vga_x", vga_x4, 0);
      check("rst_vga_y", vga_y4, 0);
      check("rst_colour", colour4, 0);
      reset = 1'b0;
      tick();

      // Shaded floor tile at (8,8)
      run_tile4(8, 8, 0, 0, 0, 0, 1'b0, 1'b0, 24);
      check("t1_plots", q_x.size(), 16);
      bad = 0;
      for (int i = 0; i < q_x.size(); i++)
         if (q_x[i] != 8 + i % 4 || q_y[i] != 8 + i / 4) bad++;
      check("t1_raster_order", bad, 0);
      if (q_x.size() == 16) begin
         check("t1_c_8_8", q_c[0], 9'b101_010_010);
         check("t1_c_11_9", q_c[7], 9'b101_010_010);
         check("t1_c_8_11", q_c[12], 9'b010_000_000);
         check("t1_c_9_9", q_c[5], 9'b101_010_000);
         check("t1_first_plot_cyc", q_cyc[0], 1);
         check("t1_last_plot_cyc", q_cyc[15], 16);
      end
      check("t1_done_cyc", done_cyc, 17);
      check("t1_done_count", n_done, 1);
      check("t1_ready_at_done", ready_at_done, 1);

      // Outline wall tile, TILE_SIZE=8, origin (0,0)
      px = 8'd0; py = 7'd0; tile_type = 2'd1; mode = 2'd2;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      cnt = 0; bad = 0; done_cyc = -1; cyc = 0;
      while (cyc < 80) begin
         tick();
         cyc++;
         if (plot8) begin
            cnt++;
            if (colour8 != 9'b010_010_010) bad++;
            if (!(vga_x8 == 0 || vga_x8 == 7 || vga_y8 == 0 || vga_y8 == 7)) bad++;
         end
         if (done8 && done_cyc < 0) done_cyc = cyc;
      end
      check("t2_border_plots", cnt, 28);
      check("t2_bad_pixels", bad, 0);
      check("t2_done_cyc", done_cyc, 65);

      // Clipping at bottom-right screen corner
      run_tile4(158, 118, 0, 0, 0, 0, 1'b0, 1'b0, 24);
      check("t3_plots", q_x.size(), 4);
      if (q_x.size() == 4) begin
         check("t3_p0", q_x[0] * 1000 + q_y[0], 158118);
         check("t3_p1", q_x[1] * 1000 + q_y[1], 159118);
         check("t3_p2", q_x[2] * 1000 + q_y[2], 158119);
         check("t3_p3", q_x[3] * 1000 + q_y[3], 159119);
      end
      check("t3_done_cyc", done_cyc, 17);

      // Hold for 5 cycles after 3 pixels
      run_tile4(20, 30, 1, 1, 3, 5, 1'b0, 1'b0, 32);
      check("t4_plots", q_x.size(), 16);
      cnt = 0;
      foreach (q_cyc[i]) if (q_cyc[i] >= 4 && q_cyc[i] <= 8) cnt++;
      check("t4_plots_in_hold", cnt, 0);
      if (q_x.size() == 16) begin
         check("t4_p3_xy", q_x[3] * 1000 + q_y[3], 23030);
         check("t4_p3_cyc", q_cyc[3], 9);
         bad = 0;
         for (int i = 0; i < 16; i++)
            if (q_x[i] != 20 + i % 4 || q_y[i] != 30 + i / 4) bad++;
         check("t4_no_skip_dup", bad, 0);
      end
      check("t4_done_cyc", done_cyc, 22);

      // Starts while busy and during DONE are ignored
      run_tile4(40, 40, 3, 1, 0, 0, 1'b1, 1'b1, 40);
      check("t5_plots", q_x.size(), 16);
      bad = 0;
      foreach (q_c[i]) if (q_c[i] != 9'b110_110_000) bad++;
      check("t5_solid_colour", bad, 0);
      check("t5_done_count", n_done, 1);
      check("t5_done_cyc", done_cyc, 17);
      check("t5_idle_after", ready4, 1);

      // Reset during the 7th pixel
      px = 8'd50; py = 7'd50; tile_type = 2'd0; mode = 2'd0;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("t6_pre_busy", busy4, 1);
      reset = 1'b1;
      tick();
      check("t6_plot", plot4, 0);
      check("t6_ready", ready4, 1);
      check("t6_busy", busy4, 0);
      check("t6_colour", colour4, 0);
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done4) cnt++;
      end
      check("t6_no_done", cnt, 0);
      run_tile4(0, 0, 1, 0, 0, 0, 1'b0, 1'b0, 24);
      check("t6_fresh_plots", q_x.size(), 16);
      if (q_x.size() == 16) check("t6_fresh_c_0_0", q_c[0], 9'b110_110_110);
      check("t6_fresh_done_cyc", done_cyc, 17);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
